axi4_lite_master: RTL
=====================

Name: axi4_lite_master

Overview:
- AXI4-Lite master bridge. It sits directly upstream of the register-file slave.
- Converts a simple single-beat command interface (start/write/addr/data) into full AW/W/B or AR/R channel handshakes.
- Returns read data and response to the requester.
- One outstanding transaction at a time; fixed 4-bit address and 32-bit data, matching the slave.

Parameters:
ADDR_W, 4, address width on cmd_addr/AWADDR/ARADDR
DATA_W, 32, data width on cmd_wdata/WDATA/RDATA/cmd_rdata

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  reset, asynchronous, active-high
cmd_start  in  1  request pulse; accepted only when cmd_ready=1
cmd_write  in  1  1=write, 0=read; sampled with cmd_start
cmd_addr  in  ADDR_W  byte address; sampled with cmd_start
cmd_wdata  in  DATA_W  write data; sampled with cmd_start
cmd_ready  out  1  high in IDLE only
cmd_done  out  1  one-cycle pulse when transaction completes
cmd_rdata  out  DATA_W  captured RDATA; holds until next read completes
cmd_resp  out  2  captured BRESP/RRESP; holds until next completion
AWADDR  out  ADDR_W ; AWVALID out 1 ; AWREADY in 1
WDATA  out  DATA_W ; WVALID out 1 ; WREADY in 1
BRESP  in  2 ; BVALID in 1 ; BREADY out 1
ARADDR  out  ADDR_W ; ARVALID out 1 ; ARREADY in 1
RDATA  in  DATA_W ; RVALID in 1 ; RREADY out 1 ; RRESP in 2

Behaviour:
- Reset (ARESETn=1, async): state=IDLE.
  - All VALID/READY outputs 0; cmd_done=0; cmd_ready=1.
  - cmd_rdata=0, cmd_resp=0, AWADDR/ARADDR/WDATA=0.
  - Reset mid-transaction drops every VALID immediately; no completion pulse is issued.
- All outputs are registered except cmd_ready, which is decoded from state.
- States: IDLE, W_ADDR_DATA, W_RESP, R_ADDR, R_DATA.
- IDLE: on cmd_start=1, latch addr/wdata.
  - cmd_write=1: go to W_ADDR_DATA with AWVALID=WVALID=1 from the next cycle.
  - cmd_write=0: go to R_ADDR with ARVALID=1 from the next cycle.
- W_ADDR_DATA:
  - AWVALID and WVALID are independent. Each drops in the cycle after its own handshake (VALID&READY at a clock edge); aw_done/w_done flags record completion.
  - BREADY=1 throughout this state.
  - When both flags are set (same or different edges), go to W_RESP.
  - A B handshake that arrives on the same edge as, or after, the last of AW/W completes the write directly.
- W_RESP: BREADY=1. On BVALID, capture BRESP into cmd_resp, pulse cmd_done next cycle, return to IDLE.
  - The slave's BVALID may last only one cycle, so BREADY must already be high when it arrives.
- R_ADDR: ARVALID held with stable ARADDR until ARREADY; then ARVALID=0 and go to R_DATA.
- R_DATA: RREADY=1. On RVALID, capture RDATA into cmd_rdata and RRESP into cmd_resp, pulse cmd_done, return to IDLE.
- VALID is never withdrawn before its handshake. ADDR/DATA stay stable while VALID is high.
- cmd_start while busy (cmd_ready=0) is ignored, with no queueing.
- Back-to-back: cmd_start may be asserted in the same cycle cmd_done pulses, because state is already IDLE.
- Minimum latency with zero-wait slave:
  - Write: cmd_start edge to cmd_done = 3 cycles.
  - Read: 3 cycles.
- No timeout. A slave that never responds hangs the master until reset.

Test Plan:
- Write 0xDEADBEEF to addr 0x4; slave holds AWREADY/WREADY high -> AWVALID/WVALID high exactly 1 cycle, BREADY seen, cmd_done pulses once, cmd_resp=2'b00.
- Write addr 0xC; slave raises AWREADY at cycle 2 and WREADY at cycle 5 -> AWVALID low from cycle 3, WVALID held until cycle 5 handshake, WDATA stable throughout, single cmd_done.
- Read addr 0x8; slave returns RDATA=0x12345678 after 5-cycle RVALID stall -> RREADY high the whole stall, cmd_rdata=0x12345678, cmd_resp=0, cmd_done one cycle.
- Slave returns BRESP=2'b10 on write, then RRESP=2'b10 on read -> cmd_resp=2'b10 after each; cmd_rdata unchanged by the write.
- cmd_start pulsed during an active read with different addr -> ignored; ARADDR unchanged; only one AR handshake observed.
- Assert ARESETn=1 while AWVALID=1 mid-write -> AWVALID/WVALID/BREADY drop asynchronously, cmd_ready=1, no cmd_done; a following read completes normally.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns a single-beat start/write/addr/data command into AW/W/B or AR/R handshakes.
// Latency 3 cycles from the cmd_start edge to cmd_done with a zero-wait slave; one transaction in flight, cmd_start ignored while busy.
module axi4_lite_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_start,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic              cmd_done,
    output logic [DATA_W-1:0] cmd_rdata,
    output logic [1:0]        cmd_resp,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [1:0]        RRESP
);

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR_DATA,
        W_RESP,
        R_ADDR,
        R_DATA
    } state_t;

    state_t              state_q, state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                cmd_done_q, cmd_done_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cmd_rdata_q, cmd_rdata_d;
    logic [1:0]          cmd_resp_q, cmd_resp_d;

    logic aw_hs, w_hs, aw_fin, w_fin;

    assign aw_hs  = awvalid_q & AWREADY;
    assign w_hs   = wvalid_q & WREADY;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cmd_done_d  = 1'b0;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        cmd_rdata_d = cmd_rdata_q;
        cmd_resp_d  = cmd_resp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = W_ADDR_DATA;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = R_ADDR;
                    end
                end
            end

            W_ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // BREADY is already high here, so a B beat coinciding with the last AW/W beat finishes the write
                if (aw_fin && w_fin) begin
                    if (BVALID) begin
                        cmd_resp_d = BRESP;
                        cmd_done_d = 1'b1;
                        bready_d   = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d = W_RESP;
                    end
                end
            end

            W_RESP: begin
                if (BVALID) begin
                    cmd_resp_d = BRESP;
                    cmd_done_d = 1'b1;
                    bready_d   = 1'b0;
                    state_d    = IDLE;
                end
            end

            R_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R_DATA;
                end
            end

            R_DATA: begin
                if (RVALID) begin
                    cmd_rdata_d = RDATA;
                    cmd_resp_d  = RRESP;
                    cmd_done_d  = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset input is active-high despite its name
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cmd_done_q  <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            cmd_rdata_q <= '0;
            cmd_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cmd_done_q  <= cmd_done_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            cmd_rdata_q <= cmd_rdata_d;
            cmd_resp_q  <= cmd_resp_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign cmd_done  = cmd_done_q;
    assign cmd_rdata = cmd_rdata_q;
    assign cmd_resp  = cmd_resp_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule
